delay_reader: RTL
=================

// Module: delay_reader
// PURPOSE
//  Read-side address sequencer for the dual-port sample RAM in the audio delay path.
//  The write side is the incrementing address counter. This block tracks that write
//  pointer and issues read addresses trailing it by a programmable offset, so the RAM
//  behaves as an offset-sample delay line. It also produces a dout_valid strobe aligned
//  with the RAM's registered read data.
// PARAMETERS
//  WIDTH    default 9  address width; RAM depth 2**WIDTH; offset range 0..2**WIDTH-1
//  RAM_LAT  default 1  read latency of the RAM in cycles (rd_addr/rd_en -> data), >=1
// PORTS
//  clk         in   1        clock; all logic on posedge
//  rst         in   1        reset, synchronous, active-high
//  en          in   1        reader enable; low forces IDLE
//  wr_en       in   1        writer stepped this cycle (same enable the write counter sees)
//  wr_addr     in   WIDTH    address the writer uses this cycle
//  offset      in   WIDTH    delay in samples, read-pointer lag behind write pointer
//  rd_addr     out  WIDTH    RAM read address, registered
//  rd_en       out  1        RAM read strobe, registered
//  dout_valid  out  1        RAM read data valid this cycle
//  realign     out  1        one-cycle pulse: offset change detected, refill started
//  state       out  2        00 IDLE, 01 FILL, 10 RUN (11 unused)
// BEHAVIOUR
//  One clock. Reset is synchronous and active-high.
//  Reset values (rst high at a posedge):
//   - state=IDLE; rd_addr=0; rd_en=0; dout_valid=0; realign=0
//   - offset_q=0; fill_cnt=0; valid pipe all 0
//  rst has priority over every other input.
//  IDLE:
//   - rd_en=0
//   - en=1 -> capture offset_q<=offset and clear fill_cnt
//     - offset==0 -> RUN
//     - else -> FILL
//  FILL:
//   - rd_en=0
//   - each wr_en=1 cycle increments fill_cnt (WIDTH bits)
//   - when fill_cnt+1==offset_q on a wr_en cycle -> RUN (the next wr_en cycle is the first read)
//  RUN:
//   - each cycle rd_en<=wr_en
//   - on wr_en: rd_addr<=wr_addr-offset_q, modulo 2**WIDTH (wraps; no saturation)
//   - on wr_en=0: rd_addr holds
//  Latency:
//   - wr_en/wr_addr at cycle n -> rd_en/rd_addr at n+1
//   - -> dout_valid at n+1+RAM_LAT
//   - dout_valid is rd_en through a RAM_LAT-deep shift register
//  Offset change:
//   - in FILL or RUN, offset!=offset_q -> offset_q<=offset, fill_cnt<=0, realign=1 for one cycle
//   - next state is FILL (RUN if new offset==0)
//   - rd_en=0 in that cycle
//  Disable:
//   - en=0 in any state -> IDLE next cycle; rd_en=0; fill_cnt cleared
//   - valid pipe flushed to 0 in the same cycle, so no dout_valid after en drops
//   - rd_addr holds its last value
//  Simultaneous events:
//   - rst > en=0 > offset change > normal stepping
//  Boundaries:
//   - offset=2**WIDTH-1 requires 2**WIDTH-1 writes in FILL
//   - wr_addr wrap 2**WIDTH-1 -> 0 handled by modular subtraction
// TESTING
//  1) rst for 2 cycles, then idle -> state=00; rd_en=0; dout_valid=0; rd_addr=0
//  2) WIDTH=9, offset=4, en=1, wr_en=1 every cycle, wr_addr 0,1,2..
//     - FILL for 4 writes
//     - first rd_en with rd_addr=0 one cycle after wr_addr=4
//     - dout_valid RAM_LAT cycles later
//  3) Wrap: offset=4, wr_addr=2
//     - rd_addr=510 next cycle
//  4) offset 0
//     - RUN directly from IDLE
//     - rd_addr==previous-cycle wr_addr
//  5) In RUN, change offset 4->8
//     - realign=1 for one cycle, state=FILL
//     - 8 writes later RUN, rd_addr=wr_addr-8
//  6) Mid-FILL and mid-RUN
//     - drop en -> IDLE next cycle, dout_valid=0 immediately
//     - assert rst -> all outputs 0 next cycle

Source files
------------

// File: rtl/delay_reader_if.sv
// Bus between the delay-line reader and its environment.
//   en, wr_en, wr_addr, offset : driven by the environment (writer side, control)
//   rd_addr, rd_en             : RAM read port controls produced by the reader
//   dout_valid                 : RAM read data valid, aligned to the RAM output
//   realign                    : one-cycle pulse on an offset change
//   state                      : 00 IDLE, 01 FILL, 10 RUN
interface delay_reader_if #(
  parameter int WIDTH = 9
);
  logic             en;
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] rd_addr;
  logic             rd_en;
  logic             dout_valid;
  logic             realign;
  logic [1:0]       state;

  modport master (
    output en, wr_en, wr_addr, offset,
    input  rd_addr, rd_en, dout_valid, realign, state
  );

  modport slave (
    input  en, wr_en, wr_addr, offset,
    output rd_addr, rd_en, dout_valid, realign, state
  );
endinterface

// File: rtl/delay_reader.sv
// Read-side address sequencer for the delay-line sample RAM. Follows the
// write pointer and issues read addresses lagging it by 'offset' samples, and
// strobes dout_valid when the RAM's registered read data is valid.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : delay_reader_if slave (en, wr_en, wr_addr, offset in;
//          rd_addr, rd_en, dout_valid, realign, state out)
//
// state | meaning
// IDLE  | reader disabled, no reads issued
// FILL  | counting writes until the line holds 'offset' samples
// RUN   | one read per write, trailing the writer by offset_q
module delay_reader #(
  parameter int WIDTH   = 9,
  parameter int RAM_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  delay_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   offset_q, offset_d;
  logic [WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;
  logic               realign_q, realign_d;
  logic [RAM_LAT-1:0] vpipe_q, vpipe_d;
  logic [WIDTH-1:0]   fill_inc;

  assign fill_inc = fill_cnt_q + WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    fill_cnt_d = fill_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_en_d    = 1'b0;
    realign_d  = 1'b0;

    // dout_valid is rd_en delayed by the RAM read latency
    vpipe_d[0] = rd_en_q;
    for (int i = 1; i < RAM_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    if (!bus.en) begin
      // drop anything in flight so no stale dout_valid follows a disable
      state_d    = IDLE;
      fill_cnt_d = '0;
      vpipe_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          offset_d   = bus.offset;
          fill_cnt_d = '0;
          state_d    = (bus.offset == '0) ? RUN : FILL;
        end
        FILL, RUN: begin
          if (bus.offset != offset_q) begin
            offset_d   = bus.offset;
            fill_cnt_d = '0;
            realign_d  = 1'b1;
            state_d    = (bus.offset == '0) ? RUN : FILL;
          end else if (state_q == FILL) begin
            if (bus.wr_en) begin
              fill_cnt_d = fill_inc;
              if (fill_inc == offset_q) state_d = RUN;
            end
          end else begin
            rd_en_d = bus.wr_en;
            // modular subtraction handles the write-pointer wrap
            if (bus.wr_en) rd_addr_d = bus.wr_addr - offset_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      offset_q   <= '0;
      fill_cnt_q <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      realign_q  <= 1'b0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      fill_cnt_q <= fill_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      realign_q  <= realign_d;
      vpipe_q    <= vpipe_d;
    end
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.dout_valid = vpipe_q[RAM_LAT-1];
  assign bus.realign    = realign_q;
  assign bus.state      = state_q;

endmodule
